arinc_fifo_param: RTL and testbench

//  Parametrised synchronous FIFO; next generation of the ARINC429 word buffer between
//  the receive deserialiser and the host/transmit side. Adds generic width/depth,

---
 rtl/arinc_fifo_param.sv | 150 +++++++++++++++
 tb/tb_arinc_fifo_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arinc_fifo_param.sv
// rtl/arinc_fifo_param.sv - Parametrised ARINC429 word FIFO with thresholds, sticky errors and flush
//
// Synchronous FIFO buffering ARINC429 words between the receive deserialiser and
// the host/transmit side. Optional first-word-fall-through read mode is enabled
// by defining the macro FIFO_FWFT_EN; the default build is the standard
// registered-read FIFO with one clock of read latency.
//
// Parameters:
//   DATA_W     word width in bits
//   ADDR_W     address bits, DEPTH = 2**ADDR_W
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-low
//   clr           synchronous flush, active-high, overrides wr_en/rd_en
//   din           write data
//   wr_en         write request
//   rd_en         read request (acknowledge of the presented word in FWFT mode)
//   dout          read data
//   dout_valid    standard: pulses the cycle after a read; FWFT: ~empty
//   full          count == DEPTH
//   almost_full   count >= AF_THRESH
//   empty         count == 0
//   almost_empty  count <= AE_THRESH
//   count         words stored, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty

module arinc_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    generate
        if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
            $error("arinc_fifo_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W:0]   count_nxt;

    // Acceptance is judged on the registered (pre-edge) flags, so a full FIFO
    // never passes a write straight through to a simultaneous read.
    always_comb begin
        wr_acc    = wr_en & ~full;
        rd_acc    = rd_en & ~empty;
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            count        <= count_nxt;
            // Flags come from the next count so they line up with count itself.
            full         <= (count_nxt == DEPTH_C);
            almost_full  <= (count_nxt >= AF_C);
            empty        <= (count_nxt == '0);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= overflow  | (wr_en & full);
            underflow    <= underflow | (rd_en & empty);
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (rst && !clr && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally; forced to zero while empty so
    // the output never shows stale storage.
    assign dout       = empty ? '0 : mem[rd_ptr];
    assign dout_valid = ~empty;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clr) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_acc;
            if (rd_acc) dout <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_arinc_fifo_param.sv
// tb/tb_arinc_fifo_param.sv - Table-driven self-checking bench for arinc_fifo_param

module tb_arinc_fifo_param;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] dout;
    logic        dout_valid;
    logic        full;
    logic        almost_full;
    logic        empty;
    logic        almost_empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    arinc_fifo_param #(
        .DATA_W(32), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .almost_full(almost_full),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] d;
        int          cnt;
        logic        full;
        logic        af;
        logic        emp;
        logic        ae;
        logic        ovf;
        logic        unf;
        logic [31:0] dout;
        logic        dv;
    } vec_t;

    vec_t vec [34];
    logic [31:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input string name, input int cnt, input logic f, input logic af,
                             input logic e, input logic ae, input logic ovf, input logic unf);
        chk({name, ".count"}, {27'd0, count}, cnt);
        chk({name, ".full"}, {31'd0, full}, {31'd0, f});
        chk({name, ".almost_full"}, {31'd0, almost_full}, {31'd0, af});
        chk({name, ".empty"}, {31'd0, empty}, {31'd0, e});
        chk({name, ".almost_empty"}, {31'd0, almost_empty}, {31'd0, ae});
        chk({name, ".overflow"}, {31'd0, overflow}, {31'd0, ovf});
        chk({name, ".underflow"}, {31'd0, underflow}, {31'd0, unf});
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [31:0] d);
        wr_en = w; rd_en = r; clr = c; din = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    initial begin
        // Fill: count 1..16, almost_full from 14, full at 16.
        for (int i = 0; i < 16; i++) begin
            vec[i] = '{w: 1'b1, r: 1'b0, d: 32'hABFF0000 + i, cnt: i + 1,
                       full: (i == 15), af: (i + 1 >= 14), emp: 1'b0, ae: (i + 1 <= 2),
                       ovf: 1'b0, unf: 1'b0, dout: 32'h0, dv: 1'b0};
        end
        // 17th write rejected.
        vec[16] = '{w: 1'b1, r: 1'b0, d: 32'hABFF00FF, cnt: 16, full: 1'b1, af: 1'b1,
                    emp: 1'b0, ae: 1'b0, ovf: 1'b1, unf: 1'b0, dout: 32'h0, dv: 1'b0};
        // Drain in order; overflow stays sticky.
        for (int i = 0; i < 16; i++) begin
            vec[17 + i] = '{w: 1'b0, r: 1'b1, d: 32'h0, cnt: 15 - i, full: 1'b0,
                            af: (15 - i >= 14), emp: (i == 15), ae: (15 - i <= 2),
                            ovf: 1'b1, unf: 1'b0, dout: 32'hABFF0000 + i, dv: 1'b1};
        end
        // 17th read: underflow, dout holds last word.
        vec[33] = '{w: 1'b0, r: 1'b1, d: 32'h0, cnt: 0, full: 1'b0, af: 1'b0,
                    emp: 1'b1, ae: 1'b1, ovf: 1'b1, unf: 1'b1, dout: 32'hABFF000F, dv: 1'b0};

        rst = 1'b0; clr = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset.dout", dout, 32'h0);
        chk("reset.dout_valid", {31'd0, dout_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Mid-traffic asynchronous reset.
        cyc(1'b1, 1'b0, 1'b0, 32'h11110001);
        cyc(1'b1, 1'b0, 1'b0, 32'h11110002);
        cyc(1'b1, 1'b1, 1'b0, 32'h11110003);
        wr_en = 1'b1; rd_en = 1'b1; din = 32'h11110004;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_flags("midrst", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst.dout", dout, 32'h0);
        chk("midrst.dout_valid", {31'd0, dout_valid}, 32'd0);
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Fill / overflow / drain / underflow vectors.
        for (int i = 0; i < 34; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            cyc(vec[i].w, vec[i].r, 1'b0, vec[i].d);
            chk_flags(nm, vec[i].cnt, vec[i].full, vec[i].af, vec[i].emp, vec[i].ae,
                      vec[i].ovf, vec[i].unf);
`ifndef FIFO_FWFT_EN
            chk({nm, ".dout"}, dout, vec[i].dout);
            chk({nm, ".dout_valid"}, {31'd0, dout_valid}, {31'd0, vec[i].dv});
`endif
        end

        // Simultaneous read/write at count 5 for 20 cycles, pointers wrap.
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        q.delete();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'hC0DE0000 + i);
            q.push_back(32'hC0DE0000 + i);
        end
        for (int i = 0; i < 20; i++) begin
            logic [31:0] nw;
            logic [31:0] hd;
            nw = 32'hC0DE0100 + i;
            hd = q.pop_front();
            q.push_back(nw);
`ifdef FIFO_FWFT_EN
            chk($sformatf("simul%0d.dout", i), dout, hd);
`endif
            cyc(1'b1, 1'b1, 1'b0, nw);
            chk($sformatf("simul%0d.count", i), {27'd0, count}, 32'd5);
`ifndef FIFO_FWFT_EN
            chk($sformatf("simul%0d.dout", i), dout, hd);
`endif
        end

        // Simultaneous at full: read accepted, write rejected.
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 32'hF0000000 + i);
        cyc(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        chk_flags("simfull", 15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
        chk("simfull.dout", dout, 32'hF0000000);
`endif

        // Simultaneous at empty: write accepted, read rejected.
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h5A5A0001);
        chk_flags("simempty", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("simempty.after.count", {27'd0, count}, 32'd0);
`ifndef FIFO_FWFT_EN
        chk("simempty.after.dout", dout, 32'h5A5A0001);
        chk("simempty.after.dv", {31'd0, dout_valid}, 32'd1);
`endif

        // Flush at count 9 with overflow set; concurrent write is discarded.
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, 32'h77000000 + i);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk_flags("preflush", 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h99999999);
        chk_flags("flush", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush.dout", dout, 32'h0);
        chk("flush.dout_valid", {31'd0, dout_valid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk_flags("postflush", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

`ifdef FIFO_FWFT_EN
        // FWFT: word visible without rd_en, rd_en acknowledges it.
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        chk("fwft.empty.dout", dout, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'hABFFDECC);
        chk("fwft.dout", dout, 32'hABFFDECC);
        chk("fwft.dv", {31'd0, dout_valid}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("fwft.ack.empty", {31'd0, empty}, 32'd1);
        chk("fwft.ack.dv", {31'd0, dout_valid}, 32'd0);
        chk("fwft.ack.dout", dout, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
